uart_cfg: RTL and testbench
===========================

Name: uart_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART used on both the chip-side and off-chip side of the echo simulation.
- Adds configurable data width, parity mode and stop-bit count, plus an RX FIFO with occupancy count.
- Adds sticky parity, framing and overflow error flags.
- Same ready/valid byte interface; drops in wherever the current uart is instantiated, including the sim host side.

Parameters:
- CLOCK_FREQ, 1_000_000: core clock frequency, Hz.
- BAUD_RATE, 115200: line rate. Bit period is BIT_CYC = CLOCK_FREQ/BAUD_RATE, integer division (8 at the defaults).
- DATA_BITS, 8: payload bits per frame, 5..8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- RX_DEPTH, 4: RX FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- data_in  in  DATA_BITS  TX payload.
- data_in_valid  in  1  TX payload valid.
- data_in_ready  out  1  transmitter idle, payload accepted.
- data_out  out  DATA_BITS  FIFO head.
- data_out_valid  out  1  FIFO not empty.
- data_out_ready  in  1  pop FIFO head.
- rx_count  out  $clog2(RX_DEPTH+1)  FIFO occupancy.
- err_parity  out  1  sticky parity-error flag.
- err_frame  out  1  sticky framing-error flag.
- err_overflow  out  1  sticky overflow flag.
- err_clear  in  1  clears all three error flags.
- serial_in  in  1  RX line, idle high.
- serial_out  out  1  TX line, idle high.

Behaviour:
- Reset values:
  - serial_out=1, data_in_ready=1, data_out_valid=0, rx_count=0, all err_*=0.
  - data_out holds its prior value; its content is don't-care.
  - Reset mid-frame aborts both TX and RX. serial_out is 1 on the first cycle after reset deasserts.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - Each bit lasts exactly BIT_CYC cycles. Data is sent LSB first.
  - Parity bit is the XOR of the data bits (even), or its inverse (odd).
  - STOP lasts STOP_BITS*BIT_CYC cycles.
  - Accept happens on data_in_valid & data_in_ready, in IDLE only. data_in is latched on that edge.
  - data_in_ready drops in the cycle after accept.
  - serial_out goes low in the cycle after accept and stays low for BIT_CYC cycles.
  - data_in_ready returns to 1 on the cycle after the last stop cycle. Back-to-back frames have no extra idle gap.
  - data_in changes while busy are ignored.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - serial_in passes through a 2-flop synchroniser; all sampling uses the synchronised value.
  - A falling edge in IDLE starts a BIT_CYC/2 count. If the line is high at mid-start, the start is a glitch: return to IDLE with no push.
  - Each subsequent bit is sampled every BIT_CYC cycles at mid-bit. Data is received LSB first.
  - With STOP_BITS=2, the second stop bit is also sampled; both must read 1.
  - Frame end:
    - Parity mismatch: set err_parity and do not push.
    - Any stop bit reads 0: set err_frame and do not push. If the stop bit was 0, RX waits for the line to return high before re-arming IDLE.
    - Otherwise push the byte into the FIFO.
- FIFO:
  - data_out_valid = (rx_count != 0). data_out is the head entry, combinational from the storage array.
  - Pop happens on data_out_valid & data_out_ready.
  - Push to a full FIFO with no pop in the same cycle: the byte is dropped and err_overflow is set.
  - Push and pop in the same cycle when full: both succeed and rx_count is unchanged.
  - Push and pop in the same cycle when empty: push only, since valid was 0.
  - Pointers wrap modulo RX_DEPTH.
- Error flags:
  - All three are sticky until err_clear.
  - If err_clear and a new error occur in the same cycle, the flag ends set (set wins).
- TX and RX are fully independent. A loopback of serial_out to serial_in must work.

Test Plan:
- Defaults (BIT_CYC=8, 8N1), send 0xA5 -> serial_out reads 0, 1,0,1,0,0,1,0,1, 1, each bit held 8 cycles. data_in_ready is low for 80 cycles, then high.
- Loopback with PARITY=1, STOP_BITS=2, send 0x3C, 0x81, 0xFF back-to-back with data_out_ready=0 -> rx_count=3, FIFO pops yield the same bytes in order, no err_* set.
- RX_DEPTH=4, inject 5 frames with data_out_ready=0 -> rx_count=4, err_overflow=1, the 5th byte is lost. Pulse err_clear -> err_overflow=0.
- PARITY=2, drive a frame with data 0x01 and parity bit 1 -> err_parity=1, no push.
- Drive a frame with stop bit 0 -> err_frame=1, no push, and RX recovers on the next valid frame.
- Drive a 3-cycle low glitch -> no push, no error. Separately, assert reset at the 4th data bit of a TX frame -> serial_out=1 and data_in_ready=1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/uart_cfg.sv
`default_nettype none
// ============================================================================
// uart_cfg : UART with configurable data width, parity and stop bits, plus an
//            RX FIFO and sticky parity/framing/overflow error flags.
// Rev 1.0
// ============================================================================
module uart_cfg #(
    parameter int CLOCK_FREQ = 1_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int RX_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
    output logic                            err_parity,
    output logic                            err_frame,
    output logic                            err_overflow,
    input  logic                            err_clear,
    input  logic                            serial_in,
    output logic                            serial_out
);
    localparam int C_BIT_CYC = CLOCK_FREQ / BAUD_RATE;
    localparam int C_CNT_W   = $clog2(2 * C_BIT_CYC + 1);
    localparam int C_AW      = $clog2(RX_DEPTH);
    localparam int C_CW      = $clog2(RX_DEPTH + 1);

    localparam logic [C_CNT_W-1:0] c_BIT_LAST  = C_CNT_W'(C_BIT_CYC - 1);
    localparam logic [C_CNT_W-1:0] c_HALF_LAST = C_CNT_W'(C_BIT_CYC / 2 - 1);
    localparam logic [C_CNT_W-1:0] c_STOP_LAST = C_CNT_W'(STOP_BITS * C_BIT_CYC - 1);
    localparam logic [2:0]         c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic               c_PAR_EN    = (PARITY != 0);
    localparam logic               c_ODD       = (PARITY == 2);
    localparam logic               c_TWO_STOP  = (STOP_BITS == 2);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [C_CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]             r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx_par;
    logic                   w_tx_line;
    logic                   w_tx_accept;
    logic                   w_tx_bit_end;

    assign w_tx_accept  = data_in_valid & (r_tx_state == TX_IDLE);
    assign w_tx_bit_end = (r_tx_cnt == c_BIT_LAST);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + C_CNT_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_line      = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (data_in_valid) w_tx_state_nxt = TX_START;
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt = '0;
                    w_tx_bit_nxt = r_tx_bit + 3'd1;
                    if (r_tx_bit == c_DATA_LAST)
                        w_tx_state_nxt = c_PAR_EN ? TX_PAR : TX_STOP;
                end
            end
            TX_PAR: begin
                w_tx_line = r_tx_par;
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_STOP_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
        end
    end

    // Payload and parity are captured once at accept; later data_in changes are ignored.
    always_ff @(posedge clk) begin
        if (w_tx_accept) begin
            r_tx_shift <= data_in;
            r_tx_par   <= (^data_in) ^ c_ODD;
        end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
            r_tx_shift <= r_tx_shift >> 1;
        end
    end

    assign data_in_ready = (r_tx_state == TX_IDLE);
    assign serial_out    = w_tx_line;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT
    } rx_state_t;

    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic [C_CNT_W-1:0]     r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]             r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_par_err;
    logic [1:0]             r_rx_sync;
    logic                   r_rx_prev;
    logic                   w_rx;
    logic                   w_rx_fall;
    logic                   w_rx_bit_end;
    logic                   w_push;
    logic                   w_set_par;
    logic                   w_set_frame;

    assign w_rx         = r_rx_sync[1];
    assign w_rx_fall    = r_rx_prev & ~w_rx;
    assign w_rx_bit_end = (r_rx_cnt == c_BIT_LAST);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + C_CNT_W'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_push         = 1'b0;
        w_set_par      = 1'b0;
        w_set_frame    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_bit_nxt = '0;
                if (w_rx_fall) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_bit_nxt = r_rx_bit + 3'd1;
                    if (r_rx_bit == c_DATA_LAST) begin
                        w_rx_bit_nxt   = '0;
                        w_rx_state_nxt = c_PAR_EN ? RX_PAR : RX_STOP;
                    end
                end
            end
            RX_PAR: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_cnt_nxt = '0;
                    if (!w_rx) begin
                        w_set_frame    = 1'b1;
                        w_set_par      = r_rx_par_err;
                        w_rx_state_nxt = RX_WAIT;
                    end else if (c_TWO_STOP && r_rx_bit == 3'd0) begin
                        w_rx_bit_nxt = 3'd1;
                    end else begin
                        w_set_par      = r_rx_par_err;
                        w_push         = ~r_rx_par_err;
                        w_rx_state_nxt = RX_IDLE;
                    end
                end
            end
            RX_WAIT: begin
                // A low stop bit may be a held-low line; re-arm only once it is high.
                w_rx_cnt_nxt = '0;
                if (w_rx) w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_sync    <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_rx_par_err <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_sync  <= {r_rx_sync[0], serial_in};
            r_rx_prev  <= w_rx;
            if (r_rx_state == RX_IDLE)
                r_rx_par_err <= 1'b0;
            else if (r_rx_state == RX_PAR && w_rx_bit_end)
                r_rx_par_err <= w_rx ^ (^r_rx_shift) ^ c_ODD;
        end
    end

    always_ff @(posedge clk) begin
        if (r_rx_state == RX_DATA && w_rx_bit_end)
            r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]   r_mem [RX_DEPTH];
    logic [C_AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [C_CW-1:0]        r_count;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovf;

    assign w_full = (r_count == C_CW'(RX_DEPTH));
    assign w_pop  = data_out_valid & data_out_ready;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_ovf  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + C_AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + C_AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    assign data_out       = r_mem[r_rd_ptr];
    assign data_out_valid = (r_count != '0);
    assign rx_count       = r_count;

    // ------------------------------------------------------------------
    // Sticky error flags: a new error in the clear cycle wins
    // ------------------------------------------------------------------
    logic r_err_par, r_err_frame, r_err_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_par   <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_err_par   <= w_set_par   | (r_err_par   & ~err_clear);
            r_err_frame <= w_set_frame | (r_err_frame & ~err_clear);
            r_err_ovf   <= w_ovf       | (r_err_ovf   & ~err_clear);
        end
    end

    assign err_parity   = r_err_par;
    assign err_frame    = r_err_frame;
    assign err_overflow = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_cfg : directed self-checking bench for uart_cfg (8N1, 8E2 loopback,
//               8O2 receive), with a byte scoreboard queue.
// Rev 1.0
// ============================================================================
module tb_uart_cfg;
    logic clk = 1'b0;
    logic reset;
    logic err_clear;
    logic ser_drv;

    // instance a : defaults (8N1)
    logic [7:0] din_a, dout_a;
    logic       dv_in_a, rdy_a, dv_a, dr_a, ep_a, ef_a, eo_a, sout_a;
    logic [2:0] cnt_a;
    // instance b : even parity, 2 stop bits, loopback
    logic [7:0] din_b, dout_b;
    logic       dv_in_b, rdy_b, dv_b, dr_b, ep_b, ef_b, eo_b, sout_b;
    logic [2:0] cnt_b;
    // instance c : odd parity, 2 stop bits, driven line
    logic [7:0] din_c, dout_c;
    logic       dv_in_c, rdy_c, dv_c, dr_c, ep_c, ef_c, eo_c, sout_c;
    logic [2:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       tx_q[$];

    always #5 clk = ~clk;

    uart_cfg u_dut_a (
        .clk(clk), .reset(reset),
        .data_in(din_a), .data_in_valid(dv_in_a), .data_in_ready(rdy_a),
        .data_out(dout_a), .data_out_valid(dv_a), .data_out_ready(dr_a),
        .rx_count(cnt_a), .err_parity(ep_a), .err_frame(ef_a), .err_overflow(eo_a),
        .err_clear(err_clear), .serial_in(ser_drv), .serial_out(sout_a)
    );

    uart_cfg #(.PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .data_in(din_b), .data_in_valid(dv_in_b), .data_in_ready(rdy_b),
        .data_out(dout_b), .data_out_valid(dv_b), .data_out_ready(dr_b),
        .rx_count(cnt_b), .err_parity(ep_b), .err_frame(ef_b), .err_overflow(eo_b),
        .err_clear(err_clear), .serial_in(sout_b), .serial_out(sout_b)
    );

    uart_cfg #(.PARITY(2), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .reset(reset),
        .data_in(din_c), .data_in_valid(dv_in_c), .data_in_ready(rdy_c),
        .data_out(dout_c), .data_out_valid(dv_c), .data_out_ready(dr_c),
        .rx_count(cnt_c), .err_parity(ep_c), .err_frame(ef_c), .err_overflow(eo_c),
        .err_clear(err_clear), .serial_in(ser_drv), .serial_out(sout_c)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive n line bits (LSB first), each 8 cycles, then return the line to idle.
    task automatic line_frame(input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            ser_drv = v[i];
            cyc(8);
        end
        ser_drv = 1'b1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
    endtask

    // Compare FIFO head of instance sel against the scoreboard, then pop it.
    task automatic pop_chk(input int sel, input string tag);
        logic [7:0] exp_b;
        logic       v;
        logic [7:0] d;
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        v = (sel == 0) ? dv_a : (sel == 1) ? dv_b : dv_c;
        d = (sel == 0) ? dout_a : (sel == 1) ? dout_b : dout_c;
        chk({tag, "_valid"}, {31'd0, v}, 32'd1);
        chk({tag, "_data"}, {24'd0, d}, {24'd0, exp_b});
        case (sel)
            0: dr_a = 1'b1;
            1: dr_b = 1'b1;
            default: dr_c = 1'b1;
        endcase
        cyc(1);
        dr_a = 1'b0;
        dr_b = 1'b0;
        dr_c = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        logic [7:0]  lb_bytes [3];
        int          n;

        reset = 1'b1; err_clear = 1'b0; ser_drv = 1'b1;
        din_a = '0; din_b = '0; din_c = '0;
        dv_in_a = 1'b0; dv_in_b = 1'b0; dv_in_c = 1'b0;
        dr_a = 1'b0; dr_b = 1'b0; dr_c = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // reset values
        chk("rst_sout",  {31'd0, sout_a}, 32'd1);
        chk("rst_ready", {31'd0, rdy_a},  32'd1);
        chk("rst_valid", {31'd0, dv_a},   32'd0);
        chk("rst_count", {29'd0, cnt_a},  32'd0);
        chk("rst_errs",  {29'd0, ep_a, ef_a, eo_a}, 32'd0);

        // 8N1 transmit of 0xA5: start, LSB-first data, stop; 8 cycles per bit
        bits = {7'd0, 1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 8; j++) tx_q.push_back(bits[i]);
        din_a = 8'hA5; dv_in_a = 1'b1;
        cyc(1);
        dv_in_a = 1'b0;
        din_a = 8'hFF;
        for (int k = 0; k < 80; k++) begin
            chk("tx_line", {31'd0, sout_a}, {31'd0, tx_q.pop_front()});
            chk("tx_busy", {31'd0, rdy_a}, 32'd0);
            cyc(1);
        end
        chk("tx_ready_back", {31'd0, rdy_a}, 32'd1);
        chk("tx_idle_line",  {31'd0, sout_a}, 32'd1);

        // overflow: 4 frames fill the FIFO, the 5th is dropped
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back(8'(8'h11 * (f + 1)));
            line_frame(10, {6'd0, 1'b1, 8'(8'h11 * (f + 1)), 1'b0});
        end
        cyc(16);
        chk("ovf_full_count", {29'd0, cnt_a}, 32'd4);
        chk("ovf_not_yet",    {31'd0, eo_a},  32'd0);
        line_frame(10, {6'd0, 1'b1, 8'h55, 1'b0});
        cyc(16);
        chk("ovf_count", {29'd0, cnt_a}, 32'd4);
        chk("ovf_flag",  {31'd0, eo_a},  32'd1);
        chk("ovf_other", {30'd0, ep_a, ef_a}, 32'd0);
        for (int f = 0; f < 4; f++) pop_chk(0, "ovf_pop");
        chk("ovf_empty", {31'd0, dv_a}, 32'd0);
        chk("ovf_sticky", {31'd0, eo_a}, 32'd1);
        pulse_clear();
        chk("ovf_cleared", {31'd0, eo_a}, 32'd0);

        // framing error: stop bit 0, then recovery on a good frame
        line_frame(10, {6'd0, 1'b0, 8'hC3, 1'b0});
        ser_drv = 1'b0;
        cyc(16);
        ser_drv = 1'b1;
        cyc(16);
        chk("frm_flag",  {31'd0, ef_a},  32'd1);
        chk("frm_count", {29'd0, cnt_a}, 32'd0);
        exp_q.push_back(8'h5A);
        line_frame(10, {6'd0, 1'b1, 8'h5A, 1'b0});
        cyc(16);
        chk("frm_recover_count", {29'd0, cnt_a}, 32'd1);
        pop_chk(0, "frm_recover");
        pulse_clear();
        chk("frm_cleared", {31'd0, ef_a}, 32'd0);

        // 3-cycle glitch: no push, no error
        ser_drv = 1'b0;
        cyc(3);
        ser_drv = 1'b1;
        cyc(24);
        chk("glitch_count", {29'd0, cnt_a}, 32'd0);
        chk("glitch_errs",  {29'd0, ep_a, ef_a, eo_a}, 32'd0);

        // loopback, even parity, two stop bits, back-to-back
        lb_bytes[0] = 8'h3C; lb_bytes[1] = 8'h81; lb_bytes[2] = 8'hFF;
        for (int f = 0; f < 3; f++) begin
            din_b = lb_bytes[f];
            dv_in_b = 1'b1;
            n = 0;
            while (!rdy_b && n < 300) begin
                cyc(1);
                n++;
            end
            chk("lb_ready", {31'd0, rdy_b}, 32'd1);
            exp_q.push_back(lb_bytes[f]);
            cyc(1);
        end
        dv_in_b = 1'b0;
        n = 0;
        while (cnt_b != 3'd3 && n < 1000) begin
            cyc(1);
            n++;
        end
        chk("lb_count", {29'd0, cnt_b}, 32'd3);
        chk("lb_errs",  {29'd0, ep_b, ef_b, eo_b}, 32'd0);
        for (int f = 0; f < 3; f++) pop_chk(1, "lb_pop");
        chk("lb_empty", {31'd0, dv_b}, 32'd0);

        // reset in the 4th data bit of a TX frame
        din_a = 8'h33; dv_in_a = 1'b1;
        cyc(1);
        dv_in_a = 1'b0;
        cyc(34);
        chk("rst_mid_bit3", {31'd0, sout_a}, 32'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst_mid_sout",  {31'd0, sout_a}, 32'd1);
        chk("rst_mid_ready", {31'd0, rdy_a},  32'd1);
        cyc(1);
        chk("rst_mid_sout2", {31'd0, sout_a}, 32'd1);

        // odd parity: data 0x01 needs parity 0; parity 1 is an error
        line_frame(12, {4'd0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0});
        cyc(16);
        chk("par_flag",  {31'd0, ep_c},  32'd1);
        chk("par_count", {29'd0, cnt_c}, 32'd0);
        chk("par_frame", {31'd0, ef_c},  32'd0);
        exp_q.push_back(8'h01);
        line_frame(12, {4'd0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0});
        cyc(16);
        chk("par_good_count", {29'd0, cnt_c}, 32'd1);
        pop_chk(2, "par_good");
        chk("par_sticky", {31'd0, ep_c}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
